// File: rtl/byte_unstriping.sv
// Receive-side lane unstriper: four skewed byte lanes are buffered in per-lane
// FIFOs and re-serialized into one byte stream in strict lane order 0,1,2,3.
module byte_unstriping #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             unstripingCLK,
  input  logic             unstripingRST,
  input  logic [WIDTH-1:0] stripedLane0,
  input  logic [WIDTH-1:0] stripedLane1,
  input  logic [WIDTH-1:0] stripedLane2,
  input  logic [WIDTH-1:0] stripedLane3,
  input  logic [3:0]       stripedVLD,
  output logic [3:0]       laneFull,
  output logic [WIDTH-1:0] byteUnstripingOUT,
  output logic             byteUnstripingVLD,
  output logic [3:0]       overflowErr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [4][DEPTH];
  logic [AW-1:0]    wr_ptr_q [4];
  logic [AW-1:0]    wr_ptr_d [4];
  logic [AW-1:0]    rd_ptr_q [4];
  logic [AW-1:0]    rd_ptr_d [4];
  logic [CW-1:0]    count_q  [4];
  logic [CW-1:0]    count_d  [4];
  logic [1:0]       lane_ptr_q, lane_ptr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic [3:0]       err_q, err_d;
  logic [3:0]       push_s, pop_s;
  logic [WIDTH-1:0] lane_data_s [4];

  always_comb begin
    lane_data_s[0] = stripedLane0;
    lane_data_s[1] = stripedLane1;
    lane_data_s[2] = stripedLane2;
    lane_data_s[3] = stripedLane3;
  end

  // Pop is decided first so a full lane may accept a push in the cycle it is drained.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    lane_ptr_d = lane_ptr_q;
    out_d      = out_q;
    vld_d      = 1'b0;
    err_d      = err_q;
    push_s     = 4'b0000;
    pop_s      = 4'b0000;

    if (count_q[lane_ptr_q] != '0) begin
      pop_s[lane_ptr_q] = 1'b1;
      out_d             = mem_q[lane_ptr_q][rd_ptr_q[lane_ptr_q]];
      vld_d             = 1'b1;
      lane_ptr_d        = lane_ptr_q + 2'd1;
    end else begin
      lane_ptr_d = lane_ptr_q;
    end

    for (int i = 0; i < 4; i++) begin
      push_s[i] = stripedVLD[i] && ((count_q[i] != FULL_CNT) || pop_s[i]);
      if (stripedVLD[i] && !push_s[i]) begin
        err_d[i] = 1'b1;
      end else begin
        err_d[i] = err_q[i];
      end
      if (push_s[i]) begin
        wr_ptr_d[i] = wr_ptr_q[i] + AW'(1);
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i];
      end
      if (pop_s[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
      end else begin
        rd_ptr_d[i] = rd_ptr_q[i];
      end
      case ({push_s[i], pop_s[i]})
        2'b10:   count_d[i] = count_q[i] + CW'(1);
        2'b01:   count_d[i] = count_q[i] - CW'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      laneFull[i] = (count_q[i] == FULL_CNT);
    end
  end

  always_ff @(posedge unstripingCLK) begin
    if (unstripingRST) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      lane_ptr_q <= 2'd0;
      out_q      <= '0;
      vld_q      <= 1'b0;
      err_q      <= 4'b0000;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      lane_ptr_q <= lane_ptr_d;
      out_q      <= out_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge unstripingCLK) begin
    for (int i = 0; i < 4; i++) begin
      if (push_s[i] && !unstripingRST) begin
        mem_q[i][wr_ptr_q[i]] <= lane_data_s[i];
      end
    end
  end

  assign byteUnstripingOUT = out_q;
  assign byteUnstripingVLD = vld_q;
  assign overflowErr       = err_q;

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed bench for byte_unstriping: queue-based lane model checked every cycle,
// plus literal expectations on the captured output stream.
module tb_byte_unstriping;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] l0 = 8'h00, l1 = 8'h00, l2 = 8'h00, l3 = 8'h00;
  logic [3:0] v = 4'b0000;
  logic [3:0] full_o, err_o;
  logic [7:0] out_o;
  logic       vld_o;

  int tests = 0, fails = 0, cyc = 0;
  bit checking = 1'b0;
  logic [7:0] got[$];
  int got_cyc[$];

  logic [7:0] mq[4][$];
  int mptr = 0;
  logic [7:0] mout = 8'h00;
  logic mvld = 1'b0;
  logic [3:0] merr = 4'b0000;

  byte_unstriping #(.WIDTH(8), .DEPTH(D)) dut (
    .unstripingCLK(clk), .unstripingRST(rst),
    .stripedLane0(l0), .stripedLane1(l1), .stripedLane2(l2), .stripedLane3(l3),
    .stripedVLD(v), .laneFull(full_o), .byteUnstripingOUT(out_o),
    .byteUnstripingVLD(vld_o), .overflowErr(err_o));

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Lane model: serve the current lane's oldest byte, then accept pushes into queues of DEPTH.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      mptr = 0; mout = 8'h00; mvld = 1'b0; merr = 4'b0000;
    end else begin
      if (mq[mptr].size() > 0) begin
        mout = mq[mptr].pop_front();
        mvld = 1'b1;
        mptr = (mptr + 1) % 4;
      end else begin
        mvld = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (v[i]) begin
          if (mq[i].size() < D) mq[i].push_back(i == 0 ? l0 : i == 1 ? l1 : i == 2 ? l2 : l3);
          else merr[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      logic [3:0] mfull;
      for (int i = 0; i < 4; i++) mfull[i] = (mq[i].size() == D);
      check("vld", {31'd0, vld_o}, {31'd0, mvld});
      check("out", {24'd0, out_o}, {24'd0, mout});
      check("laneFull", {28'd0, full_o}, {28'd0, mfull});
      check("overflowErr", {28'd0, err_o}, {28'd0, merr});
      if (vld_o === 1'b1) begin
        got.push_back(out_o);
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic drive(logic [3:0] vv, logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d);
    v = vv; l0 = a; l1 = b; l2 = c; l3 = d;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic check_got(string name, logic [7:0] e[$]);
    check({name, "_len"}, got.size(), e.size());
    for (int i = 0; i < e.size(); i++) begin
      check(name, (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF, {24'd0, e[i]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] e[$];
    int span;

    // Test 1: reset with random lane activity
    rst = 1'b1;
    repeat (2) begin
      v = 4'($urandom); l0 = 8'($urandom); l1 = 8'($urandom);
      l2 = 8'($urandom); l3 = 8'($urandom);
      @(negedge clk);
    end
    checking = 1'b1;
    check("rst_out", {24'd0, out_o}, 32'h0);
    check("rst_vld", {31'd0, vld_o}, 32'h0);
    check("rst_full", {28'd0, full_o}, 32'h0);
    check("rst_err", {28'd0, err_o}, 32'h0);
    rst = 1'b0;
    idle(1);

    // Test 2: aligned words
    got.delete(); got_cyc.delete();
    drive(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
    idle(3);
    drive(4'b1111, 8'h55, 8'h66, 8'h77, 8'h88);
    idle(10);
    e = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    check_got("aligned", e);
    span = (got_cyc.size() == 8) ? got_cyc[7] - got_cyc[0] : -1;
    check("aligned_span", span, 7);

    // Test 3: lane 2 skewed by four cycles
    got.delete(); got_cyc.delete();
    drive(4'b1011, 8'hA0, 8'hA1, 8'h00, 8'hA3);
    idle(3);
    drive(4'b0100, 8'h00, 8'h00, 8'hA2, 8'h00);
    idle(8);
    e = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    check_got("skew", e);
    span = (got_cyc.size() == 4) ? got_cyc[2] - got_cyc[1] : -1;
    check("skew_gap", span, 3);

    // Test 4: overflow on lane 3 while lane 0 is empty
    got.delete(); got_cyc.delete();
    for (int j = 0; j < 5; j++) begin
      drive(4'b1000, 8'h00, 8'h00, 8'h00, 8'(j + 1));
      if (j == 3) check("ovf_full4", {28'd0, full_o}, 32'h8);
    end
    check("ovf_err", {28'd0, err_o}, 32'h8);
    check("ovf_full", {28'd0, full_o}, 32'h8);
    check("ovf_novld", got.size(), 0);
    for (int r = 0; r < 4; r++) begin
      drive(4'b0111, 8'(16 * (r + 1)), 8'(16 * (r + 1) + 1), 8'(16 * (r + 1) + 2), 8'h00);
      idle(3);
    end
    idle(6);
    e = '{8'h10, 8'h11, 8'h12, 8'h01, 8'h20, 8'h21, 8'h22, 8'h02,
          8'h30, 8'h31, 8'h32, 8'h03, 8'h40, 8'h41, 8'h42, 8'h04};
    check_got("drain", e);
    check("ovf_sticky", {28'd0, err_o}, 32'h8);
    rst = 1'b1; idle(1); rst = 1'b0;
    check("err_cleared", {28'd0, err_o}, 32'h0);

    // Test 5: push into full lane 0 in the same cycle it is popped
    got.delete(); got_cyc.delete();
    drive(4'b0001, 8'hC1, 8'h00, 8'h00, 8'h00);
    drive(4'b0001, 8'hC2, 8'h00, 8'h00, 8'h00);
    drive(4'b0001, 8'hC3, 8'h00, 8'h00, 8'h00);
    drive(4'b0001, 8'hC4, 8'h00, 8'h00, 8'h00);
    drive(4'b0001, 8'hC5, 8'h00, 8'h00, 8'h00);
    drive(4'b1110, 8'h00, 8'hD1, 8'hD2, 8'hD3);
    idle(3);
    check("pp_full_before", {28'd0, full_o}, 32'h1);
    drive(4'b0001, 8'hC6, 8'h00, 8'h00, 8'h00);
    check("pp_full_after", {28'd0, full_o}, 32'h1);
    check("pp_noerr", {28'd0, err_o}, 32'h0);
    idle(4);
    e = '{8'hC1, 8'hD1, 8'hD2, 8'hD3, 8'hC2};
    check_got("pushpop", e);
    rst = 1'b1; idle(1); rst = 1'b0;

    // Test 6: reset after the second byte of a word
    got.delete(); got_cyc.delete();
    drive(4'b1111, 8'h61, 8'h62, 8'h63, 8'h64);
    idle(2);
    rst = 1'b1; idle(1); rst = 1'b0;
    check("mrst_vld", {31'd0, vld_o}, 32'h0);
    check("mrst_out", {24'd0, out_o}, 32'h0);
    idle(5);
    check("mrst_discard", got.size(), 2);
    drive(4'b1111, 8'h71, 8'h72, 8'h73, 8'h74);
    idle(6);
    e = '{8'h61, 8'h62, 8'h71, 8'h72, 8'h73, 8'h74};
    check_got("mrst", e);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
